// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl
// Miss handler shared by an I-cache and a D-cache in front of one memory
// port. The D side has priority. A dirty D victim is written back first,
// then the missing line is read, then it is written into the cache for
// exactly one cycle. rdy reports, combinationally, that the controller is
// idle and no active request misses.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_re/i_addr/i_hit            instruction fetch request and tag match
//   d_re/d_we/d_addr/d_hit       data request and tag match
//   d_dirty/d_victim_tag/_line   D-cache victim information
//   m_rdy/m_rd_line              memory handshake and read data
//   m_re/m_we/m_addr/m_wr_line   memory strobes, line address, write data
//   i_fill_we/d_fill_we          one-cycle cache line write enables
//   fill_line/fill_addr          line data and line address being filled
//   rdy                          all active requests satisfied this cycle
//   i_miss_cnt/d_miss_cnt/wb_cnt saturating event counters
//
// state      | meaning
// IDLE       | serving hits, looking for a miss
// WRITE_BACK | m_we held until memory accepts the dirty victim
// D_READ     | m_re held until memory returns the D line
// I_READ     | m_re held until memory returns the I line
// D_FILL     | one cycle of d_fill_we
// I_FILL     | one cycle of i_fill_we
module cache_miss_ctrl #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 2,
  parameter int LINE_W = 64,
  parameter int CNT_W  = 16,
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_hit,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_hit,
  input  logic              d_dirty,
  input  logic [TAG_W-1:0]  d_victim_tag,
  input  logic [LINE_W-1:0] d_victim_line,
  input  logic              m_rdy,
  input  logic [LINE_W-1:0] m_rd_line,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wr_line,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [LINE_W-1:0] fill_line,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              rdy,
  output logic [CNT_W-1:0]  i_miss_cnt,
  output logic [CNT_W-1:0]  d_miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  typedef enum logic [2:0] {
    IDLE, WRITE_BACK, D_READ, I_READ, D_FILL, I_FILL
  } state_t;

  localparam int LA_W = ADDR_W - OFF_W;

  state_t          state;
  logic [LA_W-1:0] lat_line_addr;  // line address of the miss being serviced
  logic            d_miss, i_miss;
  logic            unused_off_bits;

  assign d_miss = (d_re | d_we) & ~d_hit;
  assign i_miss = i_re & ~i_hit;
  assign rdy    = (state == IDLE) & ~d_miss & ~i_miss;

  // Byte offset inside a line never reaches memory or the fill address.
  assign unused_off_bits = ^{d_addr[OFF_W-1:0], i_addr[OFF_W-1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lat_line_addr <= '0;
      m_re          <= 1'b0;
      m_we          <= 1'b0;
      m_addr        <= '0;
      m_wr_line     <= '0;
      i_fill_we     <= 1'b0;
      d_fill_we     <= 1'b0;
      fill_line     <= '0;
      fill_addr     <= '0;
      i_miss_cnt    <= '0;
      d_miss_cnt    <= '0;
      wb_cnt        <= '0;
    end else begin
      i_fill_we <= 1'b0;
      d_fill_we <= 1'b0;
      case (state)
        IDLE: begin
          if (d_miss) begin
            lat_line_addr <= d_addr[ADDR_W-1:OFF_W];
            d_miss_cnt    <= sat_inc(d_miss_cnt);
            if (d_dirty) begin
              state     <= WRITE_BACK;
              m_we      <= 1'b1;
              m_addr    <= {d_victim_tag, d_addr[OFF_W +: IDX_W], {OFF_W{1'b0}}};
              m_wr_line <= d_victim_line;
            end else begin
              state  <= D_READ;
              m_re   <= 1'b1;
              m_addr <= {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end else if (i_miss) begin
            lat_line_addr <= i_addr[ADDR_W-1:OFF_W];
            i_miss_cnt    <= sat_inc(i_miss_cnt);
            state         <= I_READ;
            m_re          <= 1'b1;
            m_addr        <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        WRITE_BACK: begin
          if (m_rdy) begin
            state  <= D_READ;
            m_we   <= 1'b0;
            m_re   <= 1'b1;
            m_addr <= {lat_line_addr, {OFF_W{1'b0}}};
            wb_cnt <= sat_inc(wb_cnt);
          end
        end
        D_READ, I_READ: begin
          if (m_rdy) begin
            m_re      <= 1'b0;
            fill_line <= m_rd_line;
            fill_addr <= {lat_line_addr, {OFF_W{1'b0}}};
            if (state == D_READ) begin
              state     <= D_FILL;
              d_fill_we <= 1'b1;
            end else begin
              state     <= I_FILL;
              i_fill_we <= 1'b1;
            end
          end
        end
        D_FILL, I_FILL: state <= IDLE;
        default: begin
          state <= IDLE;
          m_re  <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_re, i_hit, d_re, d_we, d_hit, d_dirty, m_rdy;
  logic [15:0] i_addr, d_addr;
  logic [7:0]  d_victim_tag;
  logic [63:0] d_victim_line, m_rd_line;

  logic        m_re, m_we, i_fill_we, d_fill_we, rdy;
  logic [15:0] m_addr, fill_addr, i_miss_cnt, d_miss_cnt, wb_cnt;
  logic [63:0] m_wr_line, fill_line;

  logic        s_m_re, s_m_we, s_i_fill_we, s_d_fill_we, s_rdy;
  logic [15:0] s_m_addr, s_fill_addr;
  logic [63:0] s_m_wr_line, s_fill_line;
  logic [1:0]  s_i_miss_cnt, s_d_miss_cnt, s_wb_cnt;

  int nvec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_re(i_re), .i_addr(i_addr), .i_hit(i_hit),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_hit(d_hit),
    .d_dirty(d_dirty), .d_victim_tag(d_victim_tag), .d_victim_line(d_victim_line),
    .m_rdy(m_rdy), .m_rd_line(m_rd_line),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wr_line(m_wr_line),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_line(fill_line), .fill_addr(fill_addr), .rdy(rdy),
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt), .wb_cnt(wb_cnt)
  );

  cache_miss_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_re(i_re), .i_addr(i_addr), .i_hit(i_hit),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_hit(d_hit),
    .d_dirty(d_dirty), .d_victim_tag(d_victim_tag), .d_victim_line(d_victim_line),
    .m_rdy(m_rdy), .m_rd_line(m_rd_line),
    .m_re(s_m_re), .m_we(s_m_we), .m_addr(s_m_addr), .m_wr_line(s_m_wr_line),
    .i_fill_we(s_i_fill_we), .d_fill_we(s_d_fill_we),
    .fill_line(s_fill_line), .fill_addr(s_fill_addr), .rdy(s_rdy),
    .i_miss_cnt(s_i_miss_cnt), .d_miss_cnt(s_d_miss_cnt), .wb_cnt(s_wb_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    i_re = 0; i_hit = 1; i_addr = '0;
    d_re = 0; d_we = 0; d_hit = 1; d_addr = '0;
    d_dirty = 0; d_victim_tag = '0; d_victim_line = '0;
    m_rdy = 0; m_rd_line = '0;
    step(); step();
    chk("rst_m_re", m_re, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_cnt", {i_miss_cnt, d_miss_cnt, wb_cnt}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_rdy", rdy, 1);

    // m_rdy with no miss is ignored
    m_rdy = 1; step();
    chk("ign_rdy_m_re", m_re, 0);
    chk("ign_rdy_rdy", rdy, 1);
    m_rdy = 0;

    // clean D read miss, memory answers in the third cycle
    d_re = 1; d_hit = 0; d_addr = 16'h1235; #1;
    chk("dclean_detect_rdy", rdy, 0);
    step();
    chk("dclean_m_re1", m_re, 1);
    chk("dclean_m_addr1", m_addr, 16'h1234);
    d_addr = 16'hFFFF;   // requester moves on; transfer must not follow
    step();
    chk("dclean_m_re2", m_re, 1);
    chk("dclean_m_addr2", m_addr, 16'h1234);
    step();
    chk("dclean_m_re3", {m_re, m_we}, 2'b10);
    m_rdy = 1; m_rd_line = 64'h0123_4567_89AB_CDEF;
    step();
    chk("dclean_fill_we", {d_fill_we, i_fill_we, m_re}, 3'b100);
    chk("dclean_fill_line", fill_line, 64'h0123_4567_89AB_CDEF);
    chk("dclean_fill_addr", fill_addr, 16'h1234);
    m_rdy = 0; d_re = 0; d_hit = 1;
    step();
    chk("dclean_fill_done", d_fill_we, 0);
    chk("dclean_rdy", rdy, 1);
    chk("dclean_dcnt", d_miss_cnt, 1);
    chk("dclean_wbcnt", wb_cnt, 0);

    // dirty D write miss: write back, then read, then fill
    d_we = 1; d_hit = 0; d_dirty = 1; d_victim_tag = 8'hAB;
    d_addr = 16'h5516; d_victim_line = 64'hDEAD_BEEF_0000_1111;
    step();
    chk("wb_strobes", {m_we, m_re}, 2'b10);
    chk("wb_m_addr", m_addr, 16'hAB14);
    chk("wb_line", m_wr_line, 64'hDEAD_BEEF_0000_1111);
    d_victim_tag = 8'h00; d_victim_line = '0;
    step();
    chk("wb_hold_m_addr", m_addr, 16'hAB14);
    chk("wb_hold_m_we", m_we, 1);
    m_rdy = 1; m_rd_line = 64'hAAAA_5555_AAAA_5555;
    step();
    chk("wb_dread_strobes", {m_we, m_re}, 2'b01);
    chk("wb_dread_addr", m_addr, 16'h5514);
    chk("wb_cnt1", wb_cnt, 1);
    step();
    chk("wb_fill_we", d_fill_we, 1);
    chk("wb_fill_line", fill_line, 64'hAAAA_5555_AAAA_5555);
    chk("wb_fill_addr", fill_addr, 16'h5514);
    m_rdy = 0; d_we = 0; d_hit = 1; d_dirty = 0;
    step();
    chk("wb_rdy", rdy, 1);
    chk("wb_dcnt", d_miss_cnt, 2);

    // simultaneous I and D misses: D first, then I
    i_re = 1; i_hit = 0; i_addr = 16'h0ABD;
    d_re = 1; d_hit = 0; d_addr = 16'h2001; #1;
    chk("both_detect_rdy", rdy, 0);
    step();
    chk("both_dread", {m_re, m_addr}, {1'b1, 16'h2000});
    m_rdy = 1; m_rd_line = 64'h3333_3333_3333_3333;
    step();
    chk("both_dfill", {d_fill_we, i_fill_we}, 2'b10);
    chk("both_dfill_rdy", rdy, 0);
    m_rdy = 0; d_hit = 1;
    step();
    chk("both_idle_rdy", rdy, 0);
    chk("both_idle_strobes", {m_re, m_we, d_fill_we}, 3'b000);
    step();
    chk("both_iread", {m_re, m_addr}, {1'b1, 16'h0ABC});
    chk("both_cnts", {i_miss_cnt, d_miss_cnt}, {16'd1, 16'd3});
    m_rdy = 1; m_rd_line = 64'h4444_0000_4444_0000;
    step();
    chk("both_ifill", {i_fill_we, d_fill_we}, 2'b10);
    chk("both_ifill_data", {fill_line, fill_addr}, {64'h4444_0000_4444_0000, 16'h0ABC});
    chk("both_ifill_rdy", rdy, 0);
    m_rdy = 0; i_hit = 1;
    step();
    chk("both_done_rdy", rdy, 1);
    chk("both_done_fill", i_fill_we, 0);
    i_re = 0; d_re = 0;

    // reset in the middle of a D read
    d_re = 1; d_hit = 0; d_addr = 16'h3000;
    step();
    chk("rstmid_m_re", m_re, 1);
    rst_n = 0; #1;
    chk("rstmid_cleared", {m_re, m_we, d_fill_we}, 3'b000);
    chk("rstmid_cnt", d_miss_cnt, 0);
    m_rdy = 1;
    step();
    rst_n = 1; d_re = 0; d_hit = 1; m_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstmid_no_fill", {d_fill_we, i_fill_we, m_re}, 3'b000);
    end
    chk("rstmid_rdy", rdy, 1);

    // four clean I misses: 16-bit counter reaches 4, 2-bit one saturates at 3
    for (int k = 1; k <= 4; k++) begin
      i_re = 1; i_hit = 0; i_addr = 16'(k * 16);
      step();
      m_rdy = 1;
      step();
      chk("sat_ifill", i_fill_we, 1);
      m_rdy = 0; i_hit = 1;
      step();
      chk("sat_cnt2", s_i_miss_cnt, (k > 3) ? 2'b11 : 2'(k));
    end
    chk("sat_cnt16", i_miss_cnt, 4);
    i_re = 0;

    // all hits: never stalls, memory never touched
    for (int k = 0; k < 100; k++) begin
      i_re = 1'($urandom); d_re = 1'($urandom); d_we = 1'($urandom);
      d_dirty = 1'($urandom); i_addr = 16'($urandom); d_addr = 16'($urandom);
      i_hit = 1; d_hit = 1; m_rdy = 1'($urandom);
      step();
      chk("hit_rdy", rdy, 1);
      chk("hit_strobes", {m_re, m_we}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, meaning byte/word address width.
REQ-002 SHALL provide parameter IDX_W, default 6, meaning cache index width.
REQ-003 SHALL provide parameter OFF_W, default 2, meaning line-offset width; TAG_W = ADDR_W-IDX_W-OFF_W (derived).
REQ-004 SHALL provide parameter LINE_W, default 64, meaning cache line width.
REQ-005 SHALL provide parameter CNT_W, default 16, meaning performance counter width.
REQ-006 SHALL have ports, in order:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_re  in  1  instruction fetch request
i_addr  in  ADDR_W  fetch address
i_hit  in  1  I-cache tag match
d_re  in  1  data read request
d_we  in  1  data write request
d_addr  in  ADDR_W  data address
d_hit  in  1  D-cache tag match
d_dirty  in  1  D-cache victim dirty bit
d_victim_tag  in  TAG_W  D-cache victim tag
d_victim_line  in  LINE_W  D-cache victim data
m_rdy  in  1  memory transfer complete
m_rd_line  in  LINE_W  memory read data
m_re  out  1  memory read strobe
m_we  out  1  memory write strobe
m_addr  out  ADDR_W  memory line address
m_wr_line  out  LINE_W  memory write data
i_fill_we  out  1  I-cache line write enable
d_fill_we  out  1  D-cache line write enable
fill_line  out  LINE_W  line to write into cache
fill_addr  out  ADDR_W  line address being filled
rdy  out  1  all active requests satisfied this cycle
i_miss_cnt, d_miss_cnt, wb_cnt  out  CNT_W each  event counters

Function
REQ-007 SHALL implement states IDLE, WRITE_BACK, D_READ, I_READ, D_FILL, I_FILL.
REQ-008 d_miss = (d_re|d_we)&~d_hit; i_miss = i_re&~i_hit; both combinational, evaluated only in IDLE.
REQ-009 rdy SHALL be 1 iff state==IDLE & ~d_miss & ~i_miss (combinational).
REQ-010 IDLE: d_miss&d_dirty -> WRITE_BACK; d_miss&~d_dirty -> D_READ; else i_miss -> I_READ; else stay.
REQ-011 Simultaneous d_miss and i_miss: D serviced first; I miss re-detected on return to IDLE.
REQ-012 On leaving IDLE for a D miss, SHALL latch d_addr, d_victim_tag, d_victim_line; for an I miss, latch i_addr.
REQ-013 WRITE_BACK: m_we=1, m_addr={victim_tag, latched idx, OFF_W'b0}, m_wr_line=latched victim line; on m_rdy -> D_READ, wb_cnt increments.
REQ-014 D_READ/I_READ: m_re=1, m_addr={latched addr[ADDR_W-1:OFF_W], OFF_W'b0}; on m_rdy capture m_rd_line into fill register, go to D_FILL/I_FILL.
REQ-015 D_FILL/I_FILL: exactly one cycle of d_fill_we/i_fill_we=1 with fill_line=captured data, fill_addr=line address; next state IDLE.
REQ-016 m_re and m_we SHALL never be 1 together; both 0 in IDLE and FILL states.
REQ-017 m_rdy SHALL be ignored outside WRITE_BACK/D_READ/I_READ.
REQ-018 Memory latency unbounded; states hold with strobes asserted until m_rdy.
REQ-019 Miss latency, clean: detect cycle + N memory cycles + 1 fill cycle; hit resumes in IDLE the cycle after fill.
REQ-020 d_miss_cnt/i_miss_cnt SHALL increment on IDLE->D path / IDLE->I_READ transition; all counters saturate at all-ones.
REQ-021 Requester changes to i_addr/d_addr during a miss SHALL NOT affect the transfer in progress.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, all strobes/enables 0, m_addr/m_wr_line/fill_line/fill_addr 0, counters 0.
REQ-023 Reset mid-transfer SHALL abandon the transaction; no fill enable asserted after reset release until a new miss completes.

Verification
REQ-024 Clean D read miss, d_addr=16'h1235, m_rdy after 3 cycles -> m_re=1 m_addr=16'h1234 for 3 cycles, then d_fill_we=1 one cycle, d_miss_cnt=1, wb_cnt=0.
REQ-025 Dirty D write miss, victim_tag=8'hAB, idx=6'h05 -> m_we=1 m_addr=16'hAB14 until m_rdy, then D_READ, fill; wb_cnt=1.
REQ-026 Simultaneous i_miss and d_miss (both clean) -> D_READ, D_FILL, IDLE, I_READ, I_FILL; rdy=1 only after I fill.
REQ-027 rst_n low during D_READ -> next edge m_re=0, state IDLE, counters 0; no d_fill_we observed.
REQ-028 CNT_W=2, four clean I misses -> i_miss_cnt holds 2'b11.
REQ-029 All hits over 100 random cycles -> rdy=1 whenever requests active, m_re=m_we=0 throughout.
